alu_result_select_pipe: RTL and testbench

//  Parametrised NUM_IN:1 result selector for the ALU output path, with a registered, handshaked output.

---
 rtl/alu_result_select_pipe_pkg.sv | 25 ++
 rtl/alu_result_select_pipe_if.sv | 34 +++
 rtl/alu_result_select_pipe_skid.sv | 82 ++++++++
 rtl/alu_result_select_pipe.sv | 74 +++++++
 tb/tb_alu_result_select_pipe.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_result_select_pipe_pkg.sv
// Shared types and constants for the ALU result-select pipeline.
// The skid state encoding is {out_valid, skid_valid}; 2'b01 is unreachable.
package alu_sel_pkg;

   localparam int unsigned ALU_WIDTH  = 32;
   localparam int unsigned ALU_NUM_IN = 8;
   localparam int unsigned ALU_CNT_W  = 16;

   localparam logic [1:0] EMPTY = 2'b00;
   localparam logic [1:0] ONE   = 2'b10;
   localparam logic [1:0] FULL  = 2'b11;

   typedef enum logic [1:0] {
      ST_EMPTY = EMPTY,
      ST_ONE   = ONE,
      ST_FULL  = FULL
   } skid_state_e;

   typedef struct packed {
      logic [ALU_WIDTH-1:0] data;
      logic                 zero;
      logic                 sel_err;
   } beat_t;

endpackage

// File: rtl/alu_result_select_pipe_if.sv
// Handshake bundle between the ALU units, the selector and writeback.
// master drives the selector inputs; slave is the selector side.
interface alu_result_select_pipe_if
   import alu_sel_pkg::*;
#(
   parameter int unsigned WIDTH  = ALU_WIDTH,
   parameter int unsigned NUM_IN = ALU_NUM_IN,
   parameter int unsigned CNT_W  = ALU_CNT_W
);
   localparam int unsigned SEL_W = $clog2(NUM_IN);

   logic                    flush;
   logic                    in_valid;
   logic                    in_ready;
   logic [SEL_W-1:0]        in_sel;
   logic [NUM_IN*WIDTH-1:0] in_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [WIDTH-1:0]        out_data;
   logic                    out_zero;
   logic                    out_sel_err;
   logic [CNT_W-1:0]        beat_cnt;

   modport master (
      output flush, in_valid, in_sel, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_zero, out_sel_err, beat_cnt
   );

   modport slave (
      input  flush, in_valid, in_sel, in_data, out_ready,
      output in_ready, out_valid, out_data, out_zero, out_sel_err, beat_cnt
   );

endinterface

// File: rtl/alu_result_select_pipe_skid.sv
// Generic 2-entry valid/ready skid buffer: output register plus one skid slot.
// Ready is decoded from registered state only, so there is no ready-to-ready path.
module result_skid_stage
   import alu_sel_pkg::*;
#(
   parameter type T = beat_t
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_flush,
   input  logic i_valid,
   output logic o_ready,
   input  T     i_data,
   output logic o_valid,
   input  logic i_ready,
   output T     o_data
);

   skid_state_e r_state;
   skid_state_e w_state_nxt;
   T            r_out;
   T            r_skid;
   T            w_out_nxt;
   T            w_skid_nxt;
   logic        w_accept;
   logic        w_emit;

   assign o_ready  = (r_state != ST_FULL);
   assign o_valid  = (r_state != ST_EMPTY);
   assign o_data   = r_out;
   assign w_accept = i_valid && o_ready;
   assign w_emit   = o_valid && i_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
         r_out   <= '0;
         r_skid  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_out   <= w_out_nxt;
         r_skid  <= w_skid_nxt;
      end
   end

   // Flush wins over any accept; an emit on the same edge has already completed.
   always_comb begin
      w_state_nxt = r_state;
      w_out_nxt   = r_out;
      w_skid_nxt  = r_skid;
      if (i_flush) begin
         w_state_nxt = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  w_state_nxt = ST_ONE;
                  w_out_nxt   = i_data;
               end
            end
            ST_ONE: begin
               if (w_accept && w_emit) begin
                  w_out_nxt = i_data;
               end else if (w_accept) begin
                  w_state_nxt = ST_FULL;
                  w_skid_nxt  = i_data;
               end else if (w_emit) begin
                  w_state_nxt = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (w_emit) begin
                  w_state_nxt = ST_ONE;
                  w_out_nxt   = r_skid;
               end
            end
            default: w_state_nxt = ST_EMPTY;
         endcase
      end
   end

endmodule

// File: rtl/alu_result_select_pipe.sv
// NUM_IN:1 ALU result selector with zero/select-error flags, a registered
// handshaked output through a 2-entry skid stage, and an accepted-beat counter.
module alu_result_select_pipe
   import alu_sel_pkg::*;
#(
   parameter int unsigned WIDTH  = ALU_WIDTH,
   parameter int unsigned NUM_IN = ALU_NUM_IN,
   parameter int unsigned CNT_W  = ALU_CNT_W
) (
   input logic                     clk,
   input logic                     rst_n,
   alu_result_select_pipe_if.slave io
);

   localparam int unsigned SEL_W = $clog2(NUM_IN);

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             zero;
      logic             sel_err;
   } beat_w_t;

   logic             w_sel_err;
   logic [WIDTH-1:0] w_word;
   beat_w_t          w_in_beat;
   beat_w_t          w_out_beat;
   logic             w_in_ready;
   logic [CNT_W-1:0] r_beat_cnt;

   // Out-of-range selects (possible when NUM_IN is not a power of 2) yield zero.
   always_comb begin
      w_sel_err = ({1'b0, io.in_sel} >= (SEL_W+1)'(NUM_IN));
      w_word    = '0;
      for (int unsigned k = 0; k < NUM_IN; k++) begin
         if (io.in_sel == SEL_W'(k)) begin
            w_word = io.in_data[k*WIDTH +: WIDTH];
         end
      end
   end

   assign w_in_beat.data    = w_word;
   assign w_in_beat.zero    = (w_word == '0);
   assign w_in_beat.sel_err = w_sel_err;

   result_skid_stage #(
      .T(beat_w_t)
   ) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (io.flush),
      .i_valid (io.in_valid),
      .o_ready (w_in_ready),
      .i_data  (w_in_beat),
      .o_valid (io.out_valid),
      .i_ready (io.out_ready),
      .o_data  (w_out_beat)
   );

   // Counts every accept, including one dropped by a simultaneous flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_beat_cnt <= '0;
      end else if (io.in_valid && w_in_ready) begin
         r_beat_cnt <= r_beat_cnt + CNT_W'(1);
      end
   end

   assign io.in_ready    = w_in_ready;
   assign io.out_data    = w_out_beat.data;
   assign io.out_zero    = w_out_beat.zero;
   assign io.out_sel_err = w_out_beat.sel_err;
   assign io.beat_cnt    = r_beat_cnt;

endmodule

// File: tb/tb_alu_result_select_pipe.sv
// Randomised bench for alu_result_select_pipe: a queue-based reference model
// checked every cycle, plus directed literal checks (including a NUM_IN=6 copy).
module tb_alu_result_select_pipe;

   typedef struct {
      logic [31:0] d;
      logic        z;
      logic        e;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_result_select_pipe_if #(.WIDTH(32), .NUM_IN(8), .CNT_W(16)) ifa ();
   alu_result_select_pipe_if #(.WIDTH(32), .NUM_IN(6), .CNT_W(16)) ifb ();

   alu_result_select_pipe #(.WIDTH(32), .NUM_IN(8), .CNT_W(16)) u_dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (ifa.slave)
   );

   alu_result_select_pipe #(.WIDTH(32), .NUM_IN(6), .CNT_W(16)) u_dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (ifb.slave)
   );

   int          n_vec  = 0;
   int          n_err  = 0;
   int          n_emit = 0;
   logic [15:0] m_cnt  = 16'h0;
   exp_t        q[$];

   task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input int sel, input int num_in, input logic [255:0] d);
      exp_t        e;
      logic [255:0] sh;
      if (sel >= num_in) begin
         e.d = 32'h0;
         e.e = 1'b1;
      end else begin
         sh  = d >> (32 * sel);
         e.d = sh[31:0];
         e.e = 1'b0;
      end
      e.z = (e.d == 32'h0);
      return e;
   endfunction

   function automatic logic [255:0] rnd_words();
      logic [255:0] r;
      logic [31:0]  w;
      r = '0;
      for (int k = 0; k < 8; k++) begin
         w = $urandom;
         if ($urandom_range(0, 7) == 0) w = 32'h0;
         r[k*32 +: 32] = w;
      end
      return r;
   endfunction

   // Reference model: an ordered queue holding at most two beats.
   always @(negedge clk) begin
      bit rdy, vld;
      if (!rst_n) begin
         cmp("rst_out_valid", 64'(ifa.out_valid), 64'd0);
         cmp("rst_in_ready", 64'(ifa.in_ready), 64'd1);
         cmp("rst_beat_cnt", 64'(ifa.beat_cnt), 64'd0);
         q.delete();
         m_cnt = 16'h0;
      end else begin
         rdy = (q.size() < 2);
         vld = (q.size() > 0);
         cmp("in_ready", 64'(ifa.in_ready), 64'(rdy));
         cmp("out_valid", 64'(ifa.out_valid), 64'(vld));
         if (vld) begin
            cmp("out_data", 64'(ifa.out_data), 64'(q[0].d));
            cmp("out_zero", 64'(ifa.out_zero), 64'(q[0].z));
            cmp("out_sel_err", 64'(ifa.out_sel_err), 64'(q[0].e));
         end
         cmp("beat_cnt", 64'(ifa.beat_cnt), 64'(m_cnt));
         if (vld && ifa.out_ready) begin
            void'(q.pop_front());
            n_emit++;
         end
         if (ifa.in_valid && rdy) m_cnt = m_cnt + 16'h1;
         if (ifa.flush) q.delete();
         else if (ifa.in_valid && rdy) q.push_back(model(int'(ifa.in_sel), 8, ifa.in_data));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic v, input logic [2:0] s, input logic [255:0] d,
                          input logic ordy, input logic fl);
      ifa.in_valid  = v;
      ifa.in_sel    = s;
      ifa.in_data   = d;
      ifa.out_ready = ordy;
      ifa.flush     = fl;
   endtask

   logic [255:0] d;
   logic [191:0] db;
   logic [15:0]  cnt_before;
   int           emit_before;
   int           guard;

   initial begin
      drive_a(1'b0, 3'd0, '0, 1'b1, 1'b0);
      ifb.in_valid = 1'b0; ifb.in_sel = 3'd0; ifb.in_data = '0;
      ifb.out_ready = 1'b1; ifb.flush = 1'b0;
      #1;
      cmp("reset_out_valid", 64'(ifa.out_valid), 64'd0);
      cmp("reset_out_data", 64'(ifa.out_data), 64'd0);
      cmp("reset_in_ready", 64'(ifa.in_ready), 64'd1);
      cmp("reset_beat_cnt", 64'(ifa.beat_cnt), 64'd0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      tick();

      // Single beat, one-cycle latency
      d = rnd_words();
      d[5*32 +: 32] = 32'hDEAD_BEEF;
      drive_a(1'b1, 3'd5, d, 1'b1, 1'b0);
      tick();
      drive_a(1'b0, 3'd0, '0, 1'b1, 1'b0);
      cmp("t1_out_valid", 64'(ifa.out_valid), 64'd1);
      cmp("t1_out_data", 64'(ifa.out_data), 64'hDEAD_BEEF);
      cmp("t1_out_zero", 64'(ifa.out_zero), 64'd0);
      cmp("t1_beat_cnt", 64'(ifa.beat_cnt), 64'd1);
      tick();

      // Back-pressure fills the skid; drain in order
      d = rnd_words();
      d[0 +: 32] = 32'h1111_1111;
      d[7*32 +: 32] = 32'h7777_7777;
      drive_a(1'b1, 3'd0, d, 1'b0, 1'b0);
      tick();
      drive_a(1'b1, 3'd7, d, 1'b0, 1'b0);
      tick();
      drive_a(1'b0, 3'd0, '0, 1'b0, 1'b0);
      cmp("t2_full_in_ready", 64'(ifa.in_ready), 64'd0);
      cmp("t2_first_data", 64'(ifa.out_data), 64'h1111_1111);
      drive_a(1'b0, 3'd0, '0, 1'b1, 1'b0);
      tick();
      cmp("t2_second_data", 64'(ifa.out_data), 64'h7777_7777);
      cmp("t2_second_valid", 64'(ifa.out_valid), 64'd1);
      cmp("t2_in_ready_back", 64'(ifa.in_ready), 64'd1);
      tick();
      cmp("t2_drained", 64'(ifa.out_valid), 64'd0);

      // NUM_IN=6: out-of-range select and a genuine zero word
      db = 192'h0;
      for (int k = 0; k < 6; k++) db[k*32 +: 32] = 32'hA5A5_0000 | 32'(k + 1);
      ifb.in_valid = 1'b1; ifb.in_sel = 3'd7; ifb.in_data = db;
      tick();
      ifb.in_valid = 1'b0;
      cmp("t3_err_valid", 64'(ifb.out_valid), 64'd1);
      cmp("t3_err_data", 64'(ifb.out_data), 64'd0);
      cmp("t3_err_flag", 64'(ifb.out_sel_err), 64'd1);
      cmp("t3_err_zero", 64'(ifb.out_zero), 64'd1);
      db[3*32 +: 32] = 32'h0;
      ifb.in_valid = 1'b1; ifb.in_sel = 3'd3; ifb.in_data = db;
      tick();
      ifb.in_valid = 1'b0;
      cmp("t3_zero_data", 64'(ifb.out_data), 64'd0);
      cmp("t3_zero_flag", 64'(ifb.out_zero), 64'd1);
      cmp("t3_zero_err", 64'(ifb.out_sel_err), 64'd0);
      cmp("t3_b_cnt", 64'(ifb.beat_cnt), 64'd2);
      tick();

      // Flush while FULL with a beat offered: dropped, not counted
      drive_a(1'b1, 3'd1, rnd_words(), 1'b0, 1'b0);
      tick();
      drive_a(1'b1, 3'd2, rnd_words(), 1'b0, 1'b0);
      tick();
      cnt_before = m_cnt;
      drive_a(1'b1, 3'd3, rnd_words(), 1'b0, 1'b1);
      tick();
      drive_a(1'b0, 3'd0, '0, 1'b1, 1'b0);
      cmp("t4_out_valid", 64'(ifa.out_valid), 64'd0);
      cmp("t4_in_ready", 64'(ifa.in_ready), 64'd1);
      cmp("t4_beat_cnt", 64'(ifa.beat_cnt), 64'(cnt_before));
      repeat (3) tick();

      // Counter wrap
      drive_a(1'b1, 3'd4, rnd_words(), 1'b1, 1'b0);
      guard = 0;
      while (m_cnt != 16'hFFFF && guard < 70000) begin
         tick();
         guard++;
      end
      drive_a(1'b0, 3'd0, '0, 1'b1, 1'b0);
      if (guard >= 70000) cmp("t5_preload_timeout", 64'd1, 64'd0);
      cmp("t5_cnt_ffff", 64'(ifa.beat_cnt), 64'hFFFF);
      tick();
      drive_a(1'b1, 3'd6, rnd_words(), 1'b1, 1'b0);
      tick();
      drive_a(1'b0, 3'd0, '0, 1'b1, 1'b0);
      cmp("t5_cnt_wrap", 64'(ifa.beat_cnt), 64'd0);
      tick();

      // Full-rate stream: 100 beats in 100 cycles
      emit_before = n_emit;
      for (int i = 0; i < 100; i++) begin
         drive_a(1'b1, 3'($urandom_range(0, 7)), rnd_words(), 1'b1, 1'b0);
         tick();
      end
      drive_a(1'b0, 3'd0, '0, 1'b1, 1'b0);
      tick();
      cmp("t6_throughput", 64'(n_emit - emit_before), 64'd100);

      // Random traffic with back-pressure and occasional flush
      for (int i = 0; i < 300; i++) begin
         drive_a(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), rnd_words(),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
         tick();
      end

      // Reset mid-stream
      drive_a(1'b1, 3'd2, rnd_words(), 1'b0, 1'b0);
      ifb.in_valid = 1'b1; ifb.in_sel = 3'd1;
      repeat (2) tick();
      #2 rst_n = 1'b0;
      #1;
      cmp("t6_rst_valid", 64'(ifa.out_valid), 64'd0);
      cmp("t6_rst_data", 64'(ifa.out_data), 64'd0);
      cmp("t6_rst_zero", 64'(ifa.out_zero), 64'd0);
      cmp("t6_rst_err", 64'(ifa.out_sel_err), 64'd0);
      cmp("t6_rst_cnt", 64'(ifa.beat_cnt), 64'd0);
      cmp("t6_rst_in_ready", 64'(ifa.in_ready), 64'd1);
      cmp("t6_rst_b_valid", 64'(ifb.out_valid), 64'd0);
      ifb.in_valid = 1'b0;
      #10 rst_n = 1'b1;
      for (int i = 0; i < 100; i++) begin
         drive_a(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rnd_words(),
                 1'($urandom_range(0, 1)), 1'b0);
         tick();
      end
      drive_a(1'b0, 3'd0, '0, 1'b1, 1'b0);
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
